// File: rtl/alu_seg_readback_if.sv
// Command, ALU-drive and response bundle between a sequencer/ALU pair and the read-back block.
// Latency: none, this is wiring only.
// Backpressure: cmd_valid/cmd_ready and rsp_valid/rsp_ready handshakes carried as-is.
interface alu_seg_readback_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_a;
    logic [3:0] cmd_b;
    logic [2:0] cmd_op;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [2:0] alu_op;
    logic [6:0] alu_seg;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [3:0] rsp_value;
    logic [2:0] rsp_op;
    logic       rsp_err;
    logic [7:0] err_count;

    // Read-back block side.
    modport slave (
        input  cmd_valid, cmd_a, cmd_b, cmd_op, alu_seg, rsp_ready,
        output cmd_ready, alu_a, alu_b, alu_op, rsp_valid, rsp_value, rsp_op, rsp_err, err_count
    );

    // Sequencer plus ALU side.
    modport master (
        output cmd_valid, cmd_a, cmd_b, cmd_op, alu_seg, rsp_ready,
        input  cmd_ready, alu_a, alu_b, alu_op, rsp_valid, rsp_value, rsp_op, rsp_err, err_count
    );
endinterface

// File: rtl/alu_seg_readback.sv
// Drives ALU operands from accepted commands, double-samples the 7-segment output and decodes it back.
// Latency: response valid SETTLE_CYCLES+2 cycles after accept, plus SETTLE_CYCLES+2 per retry.
// Backpressure: one command in flight, cmd_ready low until the response handshake; RESP holds while rsp_ready low.
module alu_seg_readback #(
    parameter int SETTLE_CYCLES = 2,
    parameter int MAX_RETRY     = 3
) (
    input logic              clk,
    input logic              rst_n,
    alu_seg_readback_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETTLE = 3'd1,
        SAMP1  = 3'd2,
        SAMP2  = 3'd3,
        RESP   = 3'd4
    } state_t;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
    localparam logic [2:0] RETRY_LIMIT = 3'(MAX_RETRY);

    state_t     state;
    logic [3:0] settle_cnt;
    logic [2:0] retry_cnt;
    logic [6:0] s1;

    logic       cmd_ready;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [2:0] alu_op;
    logic       rsp_valid;
    logic [3:0] rsp_value;
    logic [2:0] rsp_op;
    logic       rsp_err;
    logic [7:0] err_count;

    logic [6:0] seg_hi;
    logic [3:0] dec_value;
    logic       dec_ok;

    assign seg_hi = ~bus.alu_seg;

    // Glyph-to-digit decode of the active-high segment pattern; anything off-table is invalid.
    always_comb begin
        dec_value = 4'h0;
        dec_ok    = 1'b1;
        case (seg_hi)
            7'h3F: dec_value = 4'h0;
            7'h06: dec_value = 4'h1;
            7'h5B: dec_value = 4'h2;
            7'h4F: dec_value = 4'h3;
            7'h66: dec_value = 4'h4;
            7'h6D: dec_value = 4'h5;
            7'h7D: dec_value = 4'h6;
            7'h07: dec_value = 4'h7;
            7'h7F: dec_value = 4'h8;
            7'h6F: dec_value = 4'h9;
            7'h77: dec_value = 4'hA;
            7'h7C: dec_value = 4'hB;
            7'h39: dec_value = 4'hC;
            7'h5E: dec_value = 4'hD;
            7'h79: dec_value = 4'hE;
            7'h71: dec_value = 4'hF;
            default: dec_ok = 1'b0;
        endcase
    end

    // Control FSM with all handshake and ALU-drive outputs registered.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            settle_cnt <= 4'd0;
            retry_cnt  <= 3'd0;
            s1         <= 7'd0;
            cmd_ready  <= 1'b0;
            alu_a      <= 4'd0;
            alu_b      <= 4'd0;
            alu_op     <= 3'd0;
            rsp_valid  <= 1'b0;
            rsp_value  <= 4'd0;
            rsp_op     <= 3'd0;
            rsp_err    <= 1'b0;
            err_count  <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    // cmd_ready comes back one cycle after reset release.
                    if (cmd_ready && bus.cmd_valid) begin
                        alu_a      <= bus.cmd_a;
                        alu_b      <= bus.cmd_b;
                        alu_op     <= bus.cmd_op;
                        settle_cnt <= 4'd0;
                        retry_cnt  <= 3'd0;
                        cmd_ready  <= 1'b0;
                        state      <= SETTLE;
                    end else begin
                        cmd_ready <= 1'b1;
                    end
                end
                SETTLE: begin
                    if (settle_cnt == SETTLE_LAST) begin
                        settle_cnt <= 4'd0;
                        state      <= SAMP1;
                    end else begin
                        settle_cnt <= settle_cnt + 4'd1;
                    end
                end
                SAMP1: begin
                    s1    <= bus.alu_seg;
                    state <= SAMP2;
                end
                SAMP2: begin
                    if (bus.alu_seg == s1) begin
                        rsp_value <= dec_ok ? dec_value : 4'd0;
                        rsp_err   <= ~dec_ok;
                        rsp_op    <= alu_op;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end else if (retry_cnt < RETRY_LIMIT) begin
                        // Retry is granted before the count is bumped, so MAX_RETRY retries follow the first attempt.
                        retry_cnt <= retry_cnt + 3'd1;
                        state     <= SETTLE;
                    end else begin
                        rsp_value <= 4'd0;
                        rsp_err   <= 1'b1;
                        rsp_op    <= alu_op;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        if (rsp_err && (err_count != 8'hFF)) begin
                            err_count <= err_count + 8'd1;
                        end
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.cmd_ready = cmd_ready;
    assign bus.alu_a     = alu_a;
    assign bus.alu_b     = alu_b;
    assign bus.alu_op    = alu_op;
    assign bus.rsp_valid = rsp_valid;
    assign bus.rsp_value = rsp_value;
    assign bus.rsp_op    = rsp_op;
    assign bus.rsp_err   = rsp_err;
    assign bus.err_count = err_count;

endmodule
